// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - iterative double-dabble binary-to-BCD converter
// One shift-and-add-3 step per clock, valid/ready on both sides, saturating overflow and leading-zero mask.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [DIGITS-1:0]     blank_o,
  output logic                  ovf_o
);

  if (BIN_W < 1 || BIN_W > 16) begin : g_bad_bin_w
    $error("bin_to_bcd_seq: BIN_W must be in 1..16");
  end
  if (DIGITS < 1 || DIGITS > 5) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS must be in 1..5");
  end

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int          CNT_W    = $clog2(BIN_W + 1);
  localparam int unsigned POW10    = pow10(DIGITS);
  // Clamp to 2^BIN_W so an unreachable limit never aliases when truncated to BIN_W+1 bits.
  localparam int unsigned LIMIT    = (POW10 >= (32'd1 << BIN_W)) ? (32'd1 << BIN_W) : POW10;
  localparam logic [BIN_W:0]      LIMIT_W   = LIMIT[BIN_W:0];
  localparam logic [CNT_W-1:0]    STEPS     = CNT_W'(BIN_W);
  localparam logic [DIGITS-1:0]   BLANK_RST = ~(DIGITS'(1));

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIN_W-1:0]      shift_q, shift_d;
  logic [4*DIGITS-1:0]   acc_q, acc_d;
  logic                  sat_q, sat_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]     blank_q, blank_d;
  logic                  ovf_q, ovf_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;

  logic [4*DIGITS-1:0]   acc_adj;
  logic [4*DIGITS-1:0]   bcd_load;
  logic [DIGITS-1:0]     blank_load;
  logic                  zero_run;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    bcd_d       = bcd_q;
    blank_d     = blank_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    acc_adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end

    bcd_load   = sat_q ? {DIGITS{4'h9}} : acc_q;
    zero_run   = 1'b1;
    blank_load = '0;
    // Scan from the top digit down; the ones digit is never blanked.
    for (int d = DIGITS - 1; d >= 1; d--) begin
      zero_run      = zero_run & (bcd_load[4*d +: 4] == 4'h0);
      blank_load[d] = zero_run;
    end

    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          shift_d    = bin_i;
          acc_d      = '0;
          cnt_d      = '0;
          sat_d      = ({1'b0, bin_i} >= LIMIT_W);
          in_ready_d = 1'b0;
          state_d    = CONV;
        end
      end
      CONV: begin
        if (cnt_q == STEPS) begin
          bcd_d       = bcd_load;
          blank_d     = blank_load;
          ovf_d       = sat_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          acc_d   = {acc_adj[4*DIGITS-2:0], shift_q[BIN_W-1]};
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      bcd_q       <= '0;
      blank_q     <= BLANK_RST;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      bcd_q       <= bcd_d;
      blank_q     <= blank_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign bcd_o       = bcd_q;
  assign blank_o     = blank_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed bench for bin_to_bcd_seq
// Default instance plus a BIN_W=7, DIGITS=2 instance for the full sweep.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_iv, a_ir, a_ov, a_or, a_ovf;
  logic [9:0]  a_bin;
  logic [11:0] a_bcd;
  logic [2:0]  a_blank;

  logic        b_iv, b_ir, b_ov, b_or, b_ovf;
  logic [6:0]  b_bin;
  logic [7:0]  b_bcd;
  logic [1:0]  b_blank;

  int n_checks = 0;
  int n_fail   = 0;

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(a_iv), .in_ready_o(a_ir), .bin_i(a_bin),
    .out_valid_o(a_ov), .out_ready_i(a_or),
    .bcd_o(a_bcd), .blank_o(a_blank), .ovf_o(a_ovf)
  );

  bin_to_bcd_seq #(.BIN_W(7), .DIGITS(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(b_iv), .in_ready_o(b_ir), .bin_i(b_bin),
    .out_valid_o(b_ov), .out_ready_i(b_or),
    .bcd_o(b_bcd), .blank_o(b_blank), .ovf_o(b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge.
  task automatic run_a(input logic [9:0] v, input logic [11:0] e_bcd,
                       input logic [2:0] e_blank, input logic e_ovf);
    int n;
    a_bin = v;
    a_iv  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_iv  = 1'b0;
    a_bin = ~v;
    n = 0;
    while (!a_ov && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("a_latency", n, 11);
    chk("a_bcd", a_bcd, e_bcd);
    chk("a_blank", a_blank, e_blank);
    chk("a_ovf", a_ovf, e_ovf);
    if (a_or) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_b(input logic [6:0] v, input logic [7:0] e_bcd,
                       input logic [1:0] e_blank, input logic e_ovf);
    int n;
    b_bin = v;
    b_iv  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_iv  = 1'b0;
    b_bin = ~v;
    n = 0;
    while (!b_ov && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("b_latency", n, 8);
    chk("b_bcd", b_bcd, e_bcd);
    chk("b_blank", b_blank, e_blank);
    chk("b_ovf", b_ovf, e_ovf);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic       held;
    logic [7:0] e_b;
    logic [1:0] e_bl;
    logic       e_o;

    rst_n = 1'b0;
    a_iv = 1'b0; a_bin = '0; a_or = 1'b1;
    b_iv = 1'b0; b_bin = '0; b_or = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_bcd", a_bcd, 12'h000);
    chk("rst_blank", a_blank, 3'b110);
    chk("rst_ovf", a_ovf, 1'b0);
    chk("rst_valid", a_ov, 1'b0);
    chk("rst_b_blank", b_blank, 2'b10);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", a_ir, 1'b1);

    run_a(10'd999,  12'h999, 3'b000, 1'b0);
    run_a(10'd57,   12'h057, 3'b100, 1'b0);
    run_a(10'd0,    12'h000, 3'b110, 1'b0);
    run_a(10'd1000, 12'h999, 3'b000, 1'b1);
    run_a(10'd1023, 12'h999, 3'b000, 1'b1);

    // Output stall: result must hold and a new request must be ignored.
    a_or = 1'b0;
    run_a(10'd345, 12'h345, 3'b000, 1'b0);
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin a_iv = 1'b1; a_bin = 10'd7; end
      @(posedge clk);
      @(negedge clk);
      held = held & a_ov & (a_bcd == 12'h345) & ~a_ir;
    end
    chk("stall_hold", held, 1'b1);
    a_iv = 1'b0;
    a_or = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_release_valid", a_ov, 1'b0);
    chk("stall_release_ready", a_ir, 1'b1);
    chk("stall_keep_bcd", a_bcd, 12'h345);
    run_a(10'd7, 12'h007, 3'b110, 1'b0);

    // Reset in the middle of a conversion of 321.
    a_bin = 10'd321;
    a_iv  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_iv = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", a_ov, 1'b0);
    chk("midrst_bcd", a_bcd, 12'h000);
    chk("midrst_ready", a_ir, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_a(10'd321, 12'h321, 3'b000, 1'b0);

    for (int v = 0; v < 128; v++) begin
      if (v < 100) begin
        e_b[7:4] = 4'(v / 10);
        e_b[3:0] = 4'(v % 10);
        e_bl     = (v < 10) ? 2'b10 : 2'b00;
        e_o      = 1'b0;
      end else begin
        e_b  = 8'h99;
        e_bl = 2'b00;
        e_o  = 1'b1;
      end
      run_b(7'(v), e_b, e_bl, e_o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
